// File: rtl/stopwatch_up.sv
// Count-up MM:SS stopwatch with a BCD digit chain, lap freeze and registered
// 7-segment outputs for each of the four displayed digits.
module stopwatch_up #(
    parameter bit WRAP    = 1'b0,
    parameter bit SEG_INV = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] count_bcd,
    output logic [6:0]  out_second_unit,
    output logic [6:0]  out_second_tens,
    output logic [6:0]  out_minute_unit,
    output logic [6:0]  out_minute_tens,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state;
    logic [3:0]  sec_unit;
    logic [3:0]  sec_tens;
    logic [3:0]  min_unit;
    logic [3:0]  min_tens;
    logic [15:0] lap_value;
    logic [15:0] display_value;
    logic        at_terminal;

    assign count_bcd     = {min_tens, min_unit, sec_tens, sec_unit};
    assign display_value = lap_active ? lap_value : count_bcd;
    assign at_terminal   = (min_tens == 4'd5) && (min_unit == 4'd9) &&
                           (sec_tens == 4'd5) && (sec_unit == 4'd9);

    // Digit to segment pattern {g,f,e,d,c,b,a}, polarity applied at the end.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return SEG_INV ? ~pattern : pattern;
    endfunction

    // Control FSM and counter: one prioritised action per cycle
    // (clear, then start_stop, then lap, then tick).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sec_unit   <= 4'd0;
            sec_tens   <= 4'd0;
            min_unit   <= 4'd0;
            min_tens   <= 4'd0;
            lap_value  <= 16'h0000;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
            running    <= 1'b0;
        end else begin
            if (WRAP) begin
                overflow <= 1'b0;
            end
            if (clear) begin
                state      <= IDLE;
                sec_unit   <= 4'd0;
                sec_tens   <= 4'd0;
                min_unit   <= 4'd0;
                min_tens   <= 4'd0;
                lap_active <= 1'b0;
                overflow   <= 1'b0;
                running    <= 1'b0;
            end else if (start_stop) begin
                case (state)
                    IDLE, PAUSE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (lap) begin
                if (state == RUN) begin
                    if (!lap_active) begin
                        lap_value <= count_bcd;
                    end
                    lap_active <= ~lap_active;
                end else if (state == PAUSE) begin
                    lap_active <= 1'b0;
                end
            end else if (tick && state == RUN) begin
                if (at_terminal) begin
                    overflow <= 1'b1;
                    if (WRAP) begin
                        sec_unit <= 4'd0;
                        sec_tens <= 4'd0;
                        min_unit <= 4'd0;
                        min_tens <= 4'd0;
                    end else begin
                        state   <= DONE;
                        running <= 1'b0;
                    end
                end else if (sec_unit != 4'd9) begin
                    sec_unit <= sec_unit + 4'd1;
                end else begin
                    sec_unit <= 4'd0;
                    if (sec_tens != 4'd5) begin
                        sec_tens <= sec_tens + 4'd1;
                    end else begin
                        sec_tens <= 4'd0;
                        if (min_unit != 4'd9) begin
                            min_unit <= min_unit + 4'd1;
                        end else begin
                            min_unit <= 4'd0;
                            min_tens <= min_tens + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Registered segment decode of the displayed (live or lapped) value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_second_unit <= seg_encode(4'd0);
            out_second_tens <= seg_encode(4'd0);
            out_minute_unit <= seg_encode(4'd0);
            out_minute_tens <= seg_encode(4'd0);
        end else begin
            out_second_unit <= seg_encode(display_value[3:0]);
            out_second_tens <= seg_encode(display_value[7:4]);
            out_minute_unit <= seg_encode(display_value[11:8]);
            out_minute_tens <= seg_encode(display_value[15:12]);
        end
    end

endmodule

// File: tb/tb_stopwatch_up.sv
// Bench for stopwatch_up: a saturating, active-high-segment instance and a
// wrapping, active-low-segment instance share one stimulus stream and are
// compared every cycle against a seconds-based reference model.
module tb_stopwatch_up;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;

    logic [15:0] cnt [2];
    logic [6:0]  su [2];
    logic [6:0]  st [2];
    logic [6:0]  mu [2];
    logic [6:0]  mt [2];
    logic        run [2];
    logic        lapa [2];
    logic        ovf [2];

    int total = 0;
    int bad = 0;

    // Reference model state: count held as plain seconds 0..3599.
    // mode: 0 idle, 1 run, 2 pause, 3 done.
    int mSecs [2];
    int mMode [2];
    int mLapOn [2];
    int mLapSecs [2];
    int mOv [2];
    int mShown [2];

    stopwatch_up #(.WRAP(1'b0), .SEG_INV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .lap(lap), .clear(clear), .count_bcd(cnt[0]),
        .out_second_unit(su[0]), .out_second_tens(st[0]),
        .out_minute_unit(mu[0]), .out_minute_tens(mt[0]),
        .running(run[0]), .lap_active(lapa[0]), .overflow(ovf[0])
    );

    stopwatch_up #(.WRAP(1'b1), .SEG_INV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .lap(lap), .clear(clear), .count_bcd(cnt[1]),
        .out_second_unit(su[1]), .out_second_tens(st[1]),
        .out_minute_unit(mu[1]), .out_minute_tens(mt[1]),
        .running(run[1]), .lap_active(lapa[1]), .overflow(ovf[1])
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int secs);
        int m;
        int s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [6:0] segOf(input int digit, input bit inv);
        logic [6:0] p;
        case (digit)
            0: p = 7'h3F; 1: p = 7'h06; 2: p = 7'h5B; 3: p = 7'h4F;
            4: p = 7'h66; 5: p = 7'h6D; 6: p = 7'h7D; 7: p = 7'h07;
            8: p = 7'h7F; 9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return inv ? (p ^ 7'h7F) : p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock edge of the reference model for instance i.
    task automatic modelEdge(input int i, input bit wrap);
        if (rst) begin
            mMode[i] = 0; mSecs[i] = 0; mLapOn[i] = 0; mOv[i] = 0; mShown[i] = 0;
            return;
        end
        mShown[i] = mLapOn[i] ? mLapSecs[i] : mSecs[i];
        if (wrap) mOv[i] = 0;
        if (clear) begin
            mMode[i] = 0; mSecs[i] = 0; mLapOn[i] = 0; mOv[i] = 0;
        end else if (start_stop) begin
            if (mMode[i] == 0 || mMode[i] == 2) mMode[i] = 1;
            else if (mMode[i] == 1) mMode[i] = 2;
        end else if (lap) begin
            if (mMode[i] == 1) begin
                if (mLapOn[i] != 0) mLapOn[i] = 0;
                else begin mLapSecs[i] = mSecs[i]; mLapOn[i] = 1; end
            end else if (mMode[i] == 2) mLapOn[i] = 0;
        end else if (tick && mMode[i] == 1) begin
            if (mSecs[i] == 3599) begin
                mOv[i] = 1;
                if (wrap) mSecs[i] = 0;
                else mMode[i] = 3;
            end else mSecs[i] = mSecs[i] + 1;
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 2; i++) begin
            logic [15:0] shownBcd;
            bit inv;
            inv = (i == 1);
            shownBcd = toBcd(mShown[i]);
            checkOutput($sformatf("count%0d", i), 32'(cnt[i]), 32'(toBcd(mSecs[i])));
            checkOutput($sformatf("running%0d", i), 32'(run[i]), 32'(mMode[i] == 1));
            checkOutput($sformatf("lapActive%0d", i), 32'(lapa[i]), 32'(mLapOn[i]));
            checkOutput($sformatf("overflow%0d", i), 32'(ovf[i]), 32'(mOv[i]));
            checkOutput($sformatf("segSecUnit%0d", i), 32'(su[i]), 32'(segOf(int'(shownBcd[3:0]), inv)));
            checkOutput($sformatf("segSecTens%0d", i), 32'(st[i]), 32'(segOf(int'(shownBcd[7:4]), inv)));
            checkOutput($sformatf("segMinUnit%0d", i), 32'(mu[i]), 32'(segOf(int'(shownBcd[11:8]), inv)));
            checkOutput($sformatf("segMinTens%0d", i), 32'(mt[i]), 32'(segOf(int'(shownBcd[15:12]), inv)));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after.
    task automatic applyStimulus(input bit r, input bit ss, input bit lp,
                                 input bit clr, input bit tk);
        rst = r; start_stop = ss; lap = lp; clear = clr; tick = tk;
        @(posedge clk);
        modelEdge(0, 1'b0);
        modelEdge(1, 1'b1);
        #1;
        checkAll();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("resetCount", 32'(cnt[0]), 32'h0000);
        checkOutput("resetSeg0", 32'(su[0]), 32'h3F);
        checkOutput("resetSeg1", 32'(mt[1]), 32'h40);

        // 61 ticks from zero
        applyStimulus(0, 1, 0, 0, 0);
        ticks(61);
        checkOutput("t1count", 32'(cnt[0]), 32'h0101);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1segs", {4'h0, 7'(mt[0]), 7'(mu[0]), 7'(st[0]), 7'(su[0])},
                    {4'h0, 7'h3F, 7'h06, 7'h3F, 7'h06});

        // Carry through three digits: 09:59 -> 10:00
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(599);
        checkOutput("t2pre", 32'(cnt[0]), 32'h0959);
        ticks(1);
        checkOutput("t2carry", 32'(cnt[0]), 32'h1000);

        // Terminal behaviour: run on to 59:58, then three more ticks
        ticks(2998);
        checkOutput("t3pre", 32'(cnt[0]), 32'h5958);
        ticks(1);
        checkOutput("t3at5959", 32'(cnt[1]), 32'h5959);
        ticks(1);
        checkOutput("t3satCount", 32'(cnt[0]), 32'h5959);
        checkOutput("t3satOvf", 32'(ovf[0]), 32'h1);
        checkOutput("t3satRun", 32'(run[0]), 32'h0);
        checkOutput("t4wrapCount", 32'(cnt[1]), 32'h0000);
        checkOutput("t4wrapOvf", 32'(ovf[1]), 32'h1);
        checkOutput("t4wrapRun", 32'(run[1]), 32'h1);
        ticks(1);
        checkOutput("t3stillSat", 32'(cnt[0]), 32'h5959);
        checkOutput("t4ovfPulse", 32'(ovf[1]), 32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t3doneIgnoresSs", 32'(run[0]), 32'h0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3clearCount", 32'(cnt[0]), 32'h0000);
        checkOutput("t3clearOvf", 32'(ovf[0]), 32'h0);

        // Lap freeze at 00:10 while counting continues
        applyStimulus(0, 1, 0, 0, 0);
        ticks(10);
        applyStimulus(0, 0, 1, 0, 0);
        ticks(5);
        checkOutput("t5live", 32'(cnt[0]), 32'h0015);
        checkOutput("t5frozen", {4'h0, 7'(mt[0]), 7'(mu[0]), 7'(st[0]), 7'(su[0])},
                    {4'h0, 7'h3F, 7'h3F, 7'h06, 7'h3F});
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t5resumed", 32'(su[0]), 32'h6D);

        // Tick dropped when it coincides with start_stop; then reset mid-run
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(7);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("t6paused", 32'(cnt[0]), 32'h0007);
        checkOutput("t6pausedRun", 32'(run[0]), 32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(3);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t6rstCount", 32'(cnt[0]), 32'h0000);
        checkOutput("t6rstRun", 32'(run[0]), 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 14) == 0, $urandom_range(0, 149) == 0,
                          $urandom_range(0, 1) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
